// File: rtl/char_shift_display.sv
// rtl/char_shift_display.sv - multiplexed seven-segment character scroller
//
// Holds a writable CHARS-long message of 3-bit character codes and shows a
// DIGITS-wide window of it on a time-multiplexed common-anode display.
// The window rotates once every TICK_DIV enabled clocks.
//
// Ports:
//   CLK100MHZ  system clock
//   RST        asynchronous active-high reset
//   EN         1 = scroll runs, 0 = pause (scanning continues)
//   DIR        0 = shift left (offset+1), 1 = shift right (offset-1)
//   MSG_WE     message write strobe
//   MSG_ADDR   message index to write (indices >= CHARS ignored)
//   MSG_DATA   character code to write
//   HEX0       active-low segments, HEX0[0]=a .. HEX0[6]=g (registered)
//   AN         active-low digit enables, AN[0] = rightmost (registered)
//   LEDR       current window offset
module char_shift_display #(
  parameter int DIGITS      = 8,
  parameter int CHARS       = 8,
  parameter int TICK_DIV    = 100000000,
  parameter int REFRESH_DIV = 100000,
  localparam int AW = (CHARS > 1) ? $clog2(CHARS) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic              EN,
  input  logic              DIR,
  input  logic              MSG_WE,
  input  logic [AW-1:0]     MSG_ADDR,
  input  logic [2:0]        MSG_DATA,
  output logic [0:6]        HEX0,
  output logic [DIGITS-1:0] AN,
  output logic [AW-1:0]     LEDR
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [2:0]    msg [CHARS];
  logic [AW-1:0] offset;
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] ref_cnt;
  logic [SW-1:0] scan_idx;
  logic          tick;
  logic          ref_wrap;
  logic [5:0]    idx_sum;
  logic [AW-1:0] win_idx;

  // Segment patterns, bit 6 = a .. bit 0 = g, active low.
  function automatic logic [6:0] seg_of(input logic [2:0] code);
    case (code)
      3'd0:    seg_of = 7'b1001000; // H
      3'd1:    seg_of = 7'b0110000; // E
      3'd2:    seg_of = 7'b1110001; // L
      3'd3:    seg_of = 7'b0000001; // O
      3'd4:    seg_of = 7'b1000010; // d
      3'd5:    seg_of = 7'b1001111; // 1
      3'd6:    seg_of = 7'b0010010; // 2
      default: seg_of = 7'b1111111; // blank
    endcase
  endfunction

  // Power-on message "HELLO" followed by blanks.
  function automatic logic [2:0] reset_char(input int i);
    case (i)
      0:       reset_char = 3'd0;
      1:       reset_char = 3'd1;
      2, 3:    reset_char = 3'd2;
      4:       reset_char = 3'd3;
      default: reset_char = 3'd7;
    endcase
  endfunction

  assign tick     = EN && (tick_cnt == TW'(TICK_DIV - 1));
  assign ref_wrap = (ref_cnt == RW'(REFRESH_DIV - 1));
  assign LEDR     = offset;

  // Character under the currently scanned digit. The sum never exceeds
  // 2*CHARS-1, so one conditional subtract gives the modulo.
  always_comb begin
    idx_sum = 6'(offset) + 6'(DIGITS - 1) - 6'(scan_idx);
    if (idx_sum >= 6'(CHARS)) begin
      idx_sum = idx_sum - 6'(CHARS);
    end
    win_idx = idx_sum[AW-1:0];
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      offset   <= '0;
      tick_cnt <= '0;
      ref_cnt  <= '0;
      scan_idx <= '0;
      AN       <= '1;
      HEX0     <= 7'b1111111;
      for (int i = 0; i < CHARS; i++) begin
        msg[i] <= reset_char(i);
      end
    end else begin
      // Outputs use pre-edge state: one cycle of latency by design.
      AN   <= ~(DIGITS'(1) << scan_idx);
      HEX0 <= seg_of(msg[win_idx]);

      if (EN) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      end

      if (tick) begin
        if (DIR) begin
          offset <= (offset == '0) ? AW'(CHARS - 1) : offset - 1'b1;
        end else begin
          offset <= (offset == AW'(CHARS - 1)) ? '0 : offset + 1'b1;
        end
      end

      if (ref_wrap) begin
        ref_cnt  <= '0;
        scan_idx <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end

      if (MSG_WE && (int'(MSG_ADDR) < CHARS)) begin
        msg[MSG_ADDR] <= MSG_DATA;
      end
    end
  end

endmodule

// File: tb/tb_char_shift_display.sv
// tb/tb_char_shift_display.sv - self-checking bench for char_shift_display
module tb_char_shift_display;

  localparam int DIGITS      = 4;
  localparam int CHARS       = 6;
  localparam int TICK_DIV    = 10;
  localparam int REFRESH_DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       we;
  logic [2:0] addr;
  logic [2:0] data;
  logic [0:6] hex0;
  logic [3:0] an;
  logic [2:0] ledr;

  always #5 clk = ~clk;

  char_shift_display #(
    .DIGITS(DIGITS), .CHARS(CHARS), .TICK_DIV(TICK_DIV), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .CLK100MHZ(clk), .RST(rst), .EN(en), .DIR(dir),
    .MSG_WE(we), .MSG_ADDR(addr), .MSG_DATA(data),
    .HEX0(hex0), .AN(an), .LEDR(ledr)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: edges since reset, enabled edges since reset,
  // window offset and message contents.
  int n_cyc;
  int n_en;
  int m_off;
  int m_msg [CHARS];
  logic [6:0] seg_tab [8] = '{7'b1001000, 7'b0110000, 7'b1110001, 7'b0000001,
                              7'b1000010, 7'b1001111, 7'b0010010, 7'b1111111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    int init [CHARS];
    init = '{0, 1, 2, 2, 3, 7};
    n_cyc = 0;
    n_en  = 0;
    m_off = 0;
    for (int i = 0; i < CHARS; i++) m_msg[i] = init[i];
  endtask

  // One clock edge with the currently driven inputs; checks after the edge.
  task automatic step();
    int         s;
    logic [3:0] ea;
    logic [6:0] eh;
    s  = (n_cyc / REFRESH_DIV) % DIGITS;
    ea = ~(4'b0001 << s);
    eh = seg_tab[m_msg[(m_off + DIGITS - 1 - s) % CHARS]];
    if (en) begin
      n_en++;
      if (n_en % TICK_DIV == 0)
        m_off = dir ? (m_off + CHARS - 1) % CHARS : (m_off + 1) % CHARS;
    end
    if (we && int'(addr) < CHARS) m_msg[int'(addr)] = int'(data);
    n_cyc++;
    @(posedge clk);
    #1;
    check("an", an, ea);
    check("hex0", hex0, eh);
    check("ledr", ledr, m_off);
  endtask

  // Asynchronous reset applied between edges, held for three clocks.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_an", an, 4'b1111);
    check("rst_hex0", hex0, 7'b1111111);
    check("rst_ledr", ledr, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_an", an, 4'b1111);
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; en = 1'b0; dir = 1'b0; we = 1'b0; addr = '0; data = '0;
    model_reset();
    #12;
    check("por_an", an, 4'b1111);
    check("por_hex0", hex0, 7'b1111111);
    check("por_ledr", ledr, 0);
    rst = 1'b0;

    // Paused: static HELL window, scanning continues.
    for (int k = 0; k < 100; k++) begin
      step();
      if (an == 4'b0111) check("pause_left_H", hex0, 7'b1001000);
      if (an == 4'b1110) check("pause_right_L", hex0, 7'b1110001);
    end
    check("pause_ledr", ledr, 0);

    // Scroll left through a full wrap.
    en = 1'b1; dir = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k % 10 == 0) check("fwd_ledr", ledr, (k / 10) % CHARS);
    end

    // Scroll right from offset 0.
    dir = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) check("rev_ledr_5", ledr, 5);
      if (k == 20) check("rev_ledr_4", ledr, 4);
    end

    // Write index 2 on the same edge as a tick, then out-of-range writes.
    dir = 1'b0;
    guard = 0;
    while (n_en % TICK_DIV != TICK_DIV - 1 && guard < 20) begin
      step();
      guard++;
    end
    check("tick_align", n_en % TICK_DIV, TICK_DIV - 1);
    we = 1'b1; addr = 3'd2; data = 3'd4;
    step();
    addr = 3'd6; data = 3'd0;
    step();
    addr = 3'd7; data = 3'd1;
    step();
    we = 1'b0;
    repeat (16) step();

    // Pause for 7 clocks with the tick counter at 5.
    guard = 0;
    while (n_en % TICK_DIV != 5 && guard < 20) begin
      step();
      guard++;
    end
    en = 1'b0;
    repeat (7) step();
    en = 1'b1;
    repeat (20) step();

    // Reset at offset 3 after rewriting some characters.
    we = 1'b1; addr = 3'd0; data = 3'd5;
    step();
    addr = 3'd4; data = 3'd6;
    step();
    we = 1'b0;
    guard = 0;
    while (ledr != 3'd3 && guard < 100) begin
      step();
      guard++;
    end
    check("reach_ledr3", ledr, 3);
    do_reset();
    en = 1'b0;
    repeat (16) step();

    // Randomised run with occasional asynchronous resets.
    for (int k = 0; k < 600; k++) begin
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      we   = ($urandom_range(0, 3) == 0);
      addr = 3'($urandom_range(0, 7));
      data = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) do_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
